// File: rtl/sr_pkg.sv
// Shared types for the SR latch command path.
// State/direction enums and synchronizer depth used by sr_cmd_gen.
package sr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    PULSE,
    HOLDOFF
  } sr_cmd_state_t;

  typedef enum logic {
    DIR_OFF,
    DIR_ON
  } sr_dir_t;

  localparam int SYNC_STAGES = 2;

  // Counter width able to hold n, never narrower than one bit.
  function automatic int cnt_bits(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sr_cmd_gen_sync2.sv
// Two-flop synchronizer for one asynchronous request line.
// Asynchronous active-high reset clears the whole chain.
module sync2
  import sr_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sh_q;
  logic [SYNC_STAGES-1:0] sh_d;

  always_comb begin
    sh_d = {sh_q[SYNC_STAGES-2:0], d};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sh_q <= '0;
    else       sh_q <= sh_d;
  end

  assign q = sh_q[SYNC_STAGES-1];

endmodule

// File: rtl/sr_cmd_gen.sv
// Debounced, single-owner s/r command generator for the SR latch.
// Define SR_CMD_CNT_EN to add the cmd_cnt issued-command counter.
module sr_cmd_gen
  import sr_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int PULSE_LEN  = 2,
  parameter int HOLDOFF    = 3
`ifdef SR_CMD_CNT_EN
  ,
  parameter int CNT_W      = 8
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic req_on,
  input  logic req_off,
  input  logic q_fb,
  output logic s,
  output logic r,
  output logic busy,
  output logic conflict
`ifdef SR_CMD_CNT_EN
  ,
  output logic [CNT_W-1:0] cmd_cnt
`endif
);

  localparam int DW = cnt_bits(DEB_CYCLES);
  localparam int PW = cnt_bits(PULSE_LEN);
  localparam int HW = cnt_bits(HOLDOFF);

  logic on_s;
  logic off_s;

  sync2 u_sync_on (
    .clk   (clk),
    .reset (reset),
    .d     (req_on),
    .q     (on_s)
  );

  sync2 u_sync_off (
    .clk   (clk),
    .reset (reset),
    .d     (req_off),
    .q     (off_s)
  );

  sr_cmd_state_t state_q, state_d;
  sr_dir_t       dir_q, dir_d;
  sr_dir_t       res_dir;
  logic [1:0]    cand_q, cand_d;
  logic [1:0]    pair;
  logic [DW-1:0] deb_q, deb_d;
  logic [PW-1:0] pls_q, pls_d;
  logic [HW-1:0] ho_q, ho_d;
  logic          s_q, s_d;
  logic          r_q, r_d;
  logic          conf_q, conf_d;
  logic          redundant;
  logic          go_pulse;

  assign pair = {on_s, off_s};

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    cand_d    = cand_q;
    deb_d     = deb_q;
    pls_d     = pls_q;
    ho_d      = ho_q;
    s_d       = 1'b0;
    r_d       = 1'b0;
    conf_d    = 1'b0;
    go_pulse  = 1'b0;
    // Off wins whenever both lines were captured together.
    res_dir   = (cand_q == 2'b10) ? DIR_ON : DIR_OFF;
    redundant = ((res_dir == DIR_ON) == q_fb);
    unique case (state_q)
      IDLE: begin
        if (pair != 2'b00) begin
          state_d = DEBOUNCE;
          cand_d  = pair;
          deb_d   = DW'(1);
        end
      end
      DEBOUNCE: begin
        if (pair != cand_q) begin
          state_d = IDLE;
        end else if (deb_q >= DW'(DEB_CYCLES - 1)) begin
          conf_d = &cand_q;
          dir_d  = res_dir;
          if (redundant) begin
            state_d = (HOLDOFF == 0) ? IDLE : sr_pkg::HOLDOFF;
            ho_d    = HW'(1);
          end else begin
            state_d  = PULSE;
            pls_d    = PW'(1);
            s_d      = (res_dir == DIR_OFF);
            r_d      = (res_dir == DIR_ON);
            go_pulse = 1'b1;
          end
        end else begin
          deb_d = deb_q + DW'(1);
        end
      end
      PULSE: begin
        if (pls_q >= PW'(PULSE_LEN)) begin
          state_d = (HOLDOFF == 0) ? IDLE : sr_pkg::HOLDOFF;
          ho_d    = HW'(1);
        end else begin
          pls_d = pls_q + PW'(1);
          s_d   = (dir_q == DIR_OFF);
          r_d   = (dir_q == DIR_ON);
        end
      end
      sr_pkg::HOLDOFF: begin
        if (ho_q >= HW'(HOLDOFF)) state_d = IDLE;
        else                      ho_d    = ho_q + HW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      dir_q   <= DIR_OFF;
      cand_q  <= 2'b00;
      deb_q   <= '0;
      pls_q   <= '0;
      ho_q    <= '0;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      conf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cand_q  <= cand_d;
      deb_q   <= deb_d;
      pls_q   <= pls_d;
      ho_q    <= ho_d;
      s_q     <= s_d;
      r_q     <= r_d;
      conf_q  <= conf_d;
    end
  end

  assign s        = s_q;
  assign r        = r_q;
  assign conflict = conf_q;
  assign busy     = (state_q != IDLE);

`ifdef SR_CMD_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (go_pulse) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cmd_cnt = cnt_q;
`else
  logic unused_go;
  assign unused_go = go_pulse;
`endif

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Self-checking bench for sr_cmd_gen: timestamp-based model plus
// directed scenarios with literal expectations.
module tb_sr_cmd_gen;

  localparam int DEB  = 4;
  localparam int PLEN = 2;
  localparam int HOLD = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req_on = 1'b0;
  logic req_off = 1'b0;
  logic q_fb = 1'b0;
  logic s, r, busy, conflict;
`ifdef SR_CMD_CNT_EN
  logic [1:0] cmd_cnt;
`endif

  int errors = 0;
  int checks = 0;

`ifdef SR_CMD_CNT_EN
  sr_cmd_gen #(.CNT_W(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .req_on   (req_on),
    .req_off  (req_off),
    .q_fb     (q_fb),
    .s        (s),
    .r        (r),
    .busy     (busy),
    .cmd_cnt  (cmd_cnt),
    .conflict (conflict)
  );
`else
  sr_cmd_gen dut (
    .clk      (clk),
    .reset    (reset),
    .req_on   (req_on),
    .req_off  (req_off),
    .q_fb     (q_fb),
    .s        (s),
    .r        (r),
    .busy     (busy),
    .conflict (conflict)
  );
`endif

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  int   cyc = 0;
  int   pend = 0;
  int   hend = 0;
  int   conf_c = -1;
  int   dcnt = 0;
  int   mcount = 0;
  bit   deb = 0;
  bit   m_on_dir = 0;
  logic [1:0] cand = 2'b00;
  logic m1_on = 0, m2_on = 0, m1_off = 0, m2_off = 0;

  initial forever begin
    logic [1:0] pair;
    @(posedge clk);
    cyc++;
    pair = {m2_on, m2_off};
    if (reset) begin
      deb = 0; pend = 0; hend = 0; conf_c = -1; mcount = 0;
      m1_on = 0; m2_on = 0; m1_off = 0; m2_off = 0;
    end else begin
      if (deb) begin
        if (pair == cand) begin
          dcnt++;
          if (dcnt >= DEB) begin
            deb = 0;
            m_on_dir = (cand == 2'b10);
            if (cand == 2'b11) conf_c = cyc;
            if (m_on_dir == q_fb) begin
              pend = cyc;
              hend = cyc + HOLD;
            end else begin
              pend = cyc + PLEN;
              hend = pend + HOLD;
              mcount++;
            end
          end
        end else begin
          deb = 0;
        end
      end else if (cyc - 1 >= hend && pair != 2'b00) begin
        deb = 1; cand = pair; dcnt = 1;
      end
      m2_on = m1_on;   m1_on = req_on;
      m2_off = m1_off; m1_off = req_off;
    end
  end

  initial forever begin
    logic es, er, eb, ec;
    @(negedge clk);
    if (reset) begin
      es = 0; er = 0; eb = 0; ec = 0;
    end else begin
      es = (cyc < pend) && !m_on_dir;
      er = (cyc < pend) && m_on_dir;
      eb = deb || (cyc < hend);
      ec = (cyc == conf_c);
    end
    chk("m_s", s, es);
    chk("m_r", r, er);
    chk("m_busy", busy, eb);
    chk("m_conflict", conflict, ec);
    chk("m_s_and_r", s & r, 0);
`ifdef SR_CMD_CNT_EN
    begin
      logic [1:0] ecnt;
      ecnt = reset ? 2'd0 : mcount[1:0];
      chk("m_cmd_cnt", cmd_cnt, ecnt);
    end
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  logic [1:0] cnt_tab [5];

  initial begin
    cnt_tab = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    idle(3);
    #1;
    chk("rst_s", s, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    idle(3);

    q_fb = 0;
    tick(); req_on = 1;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (c == 10) req_on = 0;
      #1;
      if (c == 5) begin chk("t1_r5", r, 0); chk("t1_b5", busy, 1); end
      if (c == 6) chk("t1_r6", r, 1);
      if (c == 7) begin chk("t1_r7", r, 1); chk("t1_s7", s, 0); end
      if (c == 8) begin chk("t1_r8", r, 0); chk("t1_b8", busy, 1); end
      if (c == 10) chk("t1_b10", busy, 1);
    end
    idle(8);

    q_fb = 1;
    tick(); req_on = 1;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (c == 8) req_on = 0;
      #1;
      if (c == 6) begin chk("t2_r6", r, 0); chk("t2_b6", busy, 1); end
      if (c == 8) chk("t2_b8", busy, 1);
      if (c == 9) chk("t2_b9", busy, 0);
    end
    idle(8);

    q_fb = 0;
    tick(); req_on = 1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 2) req_on = 0;
      #1;
      if (c == 4) chk("t3_b4", busy, 1);
      if (c == 5) begin chk("t3_b5", busy, 0); chk("t3_r5", r, 0); end
    end
    idle(5);

    q_fb = 1;
    tick(); req_on = 1; req_off = 1;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (c == 8) begin req_on = 0; req_off = 0; end
      #1;
      if (c == 5) chk("t4_c5", conflict, 0);
      if (c == 6) begin
        chk("t4_c6", conflict, 1);
        chk("t4_s6", s, 1);
        chk("t4_r6", r, 0);
      end
      if (c == 7) begin chk("t4_c7", conflict, 0); chk("t4_s7", s, 1); end
      if (c == 8) begin chk("t4_s8", s, 0); chk("t4_b8", busy, 1); end
    end
    idle(8);

    q_fb = 0;
    tick(); req_on = 1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 7) begin reset = 1; req_on = 0; end
      if (c == 9) reset = 0;
      #1;
      if (c == 6) chk("t5_r6", r, 1);
      if (c == 7) begin chk("t5_r7", r, 0); chk("t5_s7", s, 0); end
      if (c == 15) begin
        chk("t5_r15", r, 0);
        chk("t5_b15", busy, 0);
`ifdef SR_CMD_CNT_EN
        chk("t5_cnt", cmd_cnt, 0);
`endif
      end
    end

    for (int k = 0; k < 5; k++) begin
      q_fb = k[0];
      tick();
      if (k[0]) req_off = 1;
      else      req_on = 1;
      for (int c = 1; c <= 14; c++) begin
        tick();
        if (c == 8) begin req_on = 0; req_off = 0; end
        #1;
        if (c == 6) begin
          chk("t6_pulse", k[0] ? s : r, 1);
`ifdef SR_CMD_CNT_EN
          chk("t6_cnt", cmd_cnt, cnt_tab[k]);
`endif
        end
      end
      idle(4);
    end

    idle(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sr_cmd_gen.md
Name: sr_cmd_gen

Overview:
- Upstream command stage for the SR latch stage in lab1.
- Converts two raw, asynchronous request lines (req_on, req_off) into clean, debounced, single-owner s/r command pulses.
- Guarantees the latch never sees s=1 and r=1 together.
- Suppresses commands that would not change the latch's current q (fed back), and enforces a hold-off between commands.

Parameters:
- DEB_CYCLES, 4, cycles a synchronized request must stay stable high before acceptance (>=1).
- PULSE_LEN, 2, cycles an s or r command stays asserted (>=1).
- HOLDOFF, 3, idle cycles forced after each pulse before the next acceptance (>=0).
- CNT_W, 8, width of the optional command counter.

Ports:
- clk  in  1  single clock; all state on posedge clk.
- reset  in  1  asynchronous, active-high reset; async assert, sync deassert handled by the top level.
- req_on  in  1  raw request: drive latch q to 1; asynchronous to clk.
- req_off  in  1  raw request: drive latch q to 0; asynchronous to clk.
- q_fb  in  1  current latch q, synchronous to clk.
- s  out  1  latch s command; s=1, r=0 clears q (codebase latch convention).
- r  out  1  latch r command; s=0, r=1 sets q.
- busy  out  1  high in DEBOUNCE, PULSE and HOLDOFF.
- conflict  out  1  one-cycle pulse when both debounced requests are accepted in the same cycle.
- cmd_cnt  out  CNT_W  count of issued commands; only present with SR_CMD_CNT_EN.

Behaviour:
- Reset: s=0, r=0, busy=0, conflict=0, cmd_cnt=0, state=IDLE, synchronizers and counters cleared.
- Synchronization:
  - req_on and req_off each pass through a 2-flop synchronizer (on_s, off_s).
  - Requests are level-sensitive after synchronization.
  - Request-to-DEBOUNCE-entry latency is 2 cycles.
- FSM states: IDLE, DEBOUNCE, PULSE, HOLDOFF.
- IDLE:
  - If on_s or off_s is high: go to DEBOUNCE and capture the candidate pair {on_s, off_s}; deb_cnt=1.
- DEBOUNCE:
  - If the synchronized pair equals the captured pair: increment deb_cnt.
  - If the pair differs: return to IDLE without issuing; a pair of 00 also aborts.
  - When deb_cnt reaches DEB_CYCLES, accept and resolve the direction:
    - both high: direction = OFF (off wins), conflict=1 for that one cycle;
    - on only: ON;
    - off only: OFF.
  - Redundancy check after resolving: if the direction equals q_fb (ON with q_fb=1, or OFF with q_fb=0), go to HOLDOFF with no pulse.
  - Otherwise go to PULSE.
- PULSE:
  - ON drives r=1, s=0; OFF drives s=1, r=0.
  - Held exactly PULSE_LEN cycles, registered outputs.
  - Then go to HOLDOFF; with HOLDOFF=0, go straight to IDLE.
- HOLDOFF:
  - s=r=0 for HOLDOFF cycles, then IDLE.
  - A request still held high re-enters DEBOUNCE from IDLE.
  - Re-entry issues nothing if the latch already matches (redundancy check).
- Invariants:
  - s and r are never both 1.
  - Outside PULSE, s=r=0.
- Request changes during PULSE or HOLDOFF are ignored; they are not queued.
- Reset mid-PULSE: s and r drop to 0 immediately (asynchronous); no partial pulse resumes after reset.
- Counter widths: deb_cnt sized $clog2(DEB_CYCLES+1); pulse and holdoff counters sized likewise.

Optional Feature:
- Macro SR_CMD_CNT_EN.
- Defined:
  - cmd_cnt port exists.
  - Increments by 1 on the first cycle of each PULSE.
  - Wraps modulo 2^CNT_W.
  - Redundant (suppressed) commands do not count.
- Undefined: the port and counter logic are absent; all other behaviour is identical.

Decomposition:
- Package sr_pkg holds:
  - typedef enum logic [1:0] {IDLE, DEBOUNCE, PULSE, HOLDOFF} sr_cmd_state_t;
  - typedef enum logic {DIR_OFF, DIR_ON} sr_dir_t;
  - constant SYNC_STAGES=2.
- One natural sub-module: sync2, a 2-flop synchronizer with async active-high reset, instantiated twice.

Test Plan:
- Defaults, q_fb=0; req_on high 10 cycles -> r=1 for exactly 2 cycles starting 2+4 cycles after req_on rises, s stays 0, busy high through 3 holdoff cycles.
- q_fb=1; req_on held high -> no pulse, s=r=0 throughout, busy cycles through DEBOUNCE and HOLDOFF only, cmd_cnt unchanged.
- req_on glitch 2 cycles wide (less than DEB_CYCLES) -> return to IDLE, s=r=0, no count.
- q_fb=1; req_on and req_off rise together for 8 cycles -> conflict pulses once, s=1 for 2 cycles, r never 1.
- reset asserted in the second PULSE cycle -> s=r=0 the same cycle; after release with no requests, outputs stay 0 and cmd_cnt=0.
- SR_CMD_CNT_EN, CNT_W=2; issue 5 alternating real commands (toggle q_fb) -> cmd_cnt sequence 1, 2, 3, 0, 1.
